// File: rtl/dm_cache_pkg.sv
// Shared types and default geometry for the direct-mapped cache and its line memory.
package dm_cache_pkg;

    localparam int unsigned LINE_ADDR_LEN_DEF = 3;
    localparam int unsigned SET_ADDR_LEN_DEF  = 3;
    localparam int unsigned TAG_ADDR_LEN_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK
    } state_t;

endpackage

// File: rtl/dm_cache_if.sv
// CPU-side and line-memory-side signals of dm_cache; the cache uses the slave modport.
interface dm_cache_if
    import dm_cache_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
    parameter int unsigned TAG_ADDR_LEN  = TAG_ADDR_LEN_DEF
);
    localparam int unsigned WORDS        = 1 << LINE_ADDR_LEN;
    localparam int unsigned MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN;

    logic                         rd_req;
    logic                         wr_req;
    logic [31:0]                  addr;
    logic [31:0]                  wr_data;
    logic [31:0]                  rd_data;
    logic                         miss;

    logic [MEM_ADDR_LEN-1:0]      mem_addr;
    logic                         mem_rd_req;
    logic                         mem_wr_req;
    logic                         mem_gnt;
    logic [WORDS-1:0][31:0]       mem_rd_line;
    logic [WORDS-1:0][31:0]       mem_wr_line;

    logic [31:0]                  hit_cnt;
    logic [31:0]                  miss_cnt;

    modport slave (
        input  rd_req, wr_req, addr, wr_data, mem_gnt, mem_rd_line,
        output rd_data, miss, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line,
               hit_cnt, miss_cnt
    );

    modport master (
        output rd_req, wr_req, addr, wr_data, mem_gnt, mem_rd_line,
        input  rd_data, miss, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line,
               hit_cnt, miss_cnt
    );

endinterface

// File: rtl/dm_cache.sv
// Direct-mapped write-back/write-allocate cache with a line-wide memory port.
// Optional hit/miss counters are built when DM_CACHE_STATS_EN is defined.
module dm_cache
    import dm_cache_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
    parameter int unsigned TAG_ADDR_LEN  = TAG_ADDR_LEN_DEF
) (
    input  logic      clk,
    input  logic      rst,
    dm_cache_if.slave bus
);
    localparam int unsigned WORDS   = 1 << LINE_ADDR_LEN;
    localparam int unsigned SETS    = 1 << SET_ADDR_LEN;
    localparam int unsigned SET_LO  = 2 + LINE_ADDR_LEN;
    localparam int unsigned TAG_LO  = SET_LO + SET_ADDR_LEN;
    localparam int unsigned ADDR_HI = TAG_LO + TAG_ADDR_LEN;

    typedef logic [WORDS-1:0][31:0] line_t;

    line_t                    data_arr [SETS];
    logic [TAG_ADDR_LEN-1:0]  tag_arr  [SETS];
    logic [SETS-1:0]          valid;
    logic [SETS-1:0]          dirty;

    state_t                   state, state_nxt;
    logic [TAG_ADDR_LEN-1:0]  req_tag, lat_tag;
    logic [SET_ADDR_LEN-1:0]  req_set, lat_set;
    logic [LINE_ADDR_LEN-1:0] req_word;
    logic                     req, hit, serve, start_miss;
    logic                     unused_addr_bits;

    assign req_word = bus.addr[2 +: LINE_ADDR_LEN];
    assign req_set  = bus.addr[SET_LO +: SET_ADDR_LEN];
    assign req_tag  = bus.addr[TAG_LO +: TAG_ADDR_LEN];
    assign unused_addr_bits = ^{bus.addr[31:ADDR_HI], bus.addr[1:0]};

    assign req        = bus.rd_req | bus.wr_req;
    assign hit        = valid[req_set] && (tag_arr[req_set] == req_tag);
    assign serve      = (state == IDLE) && req && hit;
    assign start_miss = (state == IDLE) && req && !hit;

    // The victim line is read from the latched set, which stays untouched until SWAP_IN_OK.
    assign bus.mem_wr_line = data_arr[lat_set];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_tag <= '0;
            lat_set <= '0;
            valid   <= '0;
            dirty   <= '0;
        end else begin
            state <= state_nxt;
            if (start_miss) begin
                lat_tag <= req_tag;
                lat_set <= req_set;
            end
            if (serve && bus.wr_req && !bus.rd_req)
                dirty[req_set] <= 1'b1;
            if (state == SWAP_IN_OK) begin
                valid[lat_set] <= 1'b1;
                dirty[lat_set] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (serve && bus.wr_req && !bus.rd_req)
                data_arr[req_set][req_word] <= bus.wr_data;
            if (state == SWAP_IN_OK) begin
                data_arr[lat_set] <= bus.mem_rd_line;
                tag_arr[lat_set]  <= lat_tag;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.miss       = 1'b0;
        bus.rd_data    = '0;
        bus.mem_rd_req = 1'b0;
        bus.mem_wr_req = 1'b0;
        bus.mem_addr   = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (bus.rd_req)
                            bus.rd_data = data_arr[req_set][req_word];
                    end else begin
                        bus.miss  = 1'b1;
                        state_nxt = (valid[req_set] && dirty[req_set]) ? SWAP_OUT : SWAP_IN;
                    end
                end
            end
            SWAP_OUT: begin
                bus.miss       = req;
                bus.mem_wr_req = 1'b1;
                bus.mem_addr   = {tag_arr[lat_set], lat_set};
                if (bus.mem_gnt)
                    state_nxt = SWAP_IN;
            end
            SWAP_IN: begin
                bus.miss       = req;
                bus.mem_rd_req = 1'b1;
                bus.mem_addr   = {lat_tag, lat_set};
                if (bus.mem_gnt)
                    state_nxt = SWAP_IN_OK;
            end
            SWAP_IN_OK: begin
                bus.miss     = req;
                bus.mem_addr = {lat_tag, lat_set};
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (serve && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (start_miss && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Directed self-checking bench for dm_cache: fill, write hit, dirty eviction, reset abort.
module tb_dm_cache;
    import dm_cache_pkg::*;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;

    dm_cache_if #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN_DEF),
        .SET_ADDR_LEN (SET_ADDR_LEN_DEF),
        .TAG_ADDR_LEN (TAG_ADDR_LEN_DEF)
    ) bus ();

    dm_cache #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN_DEF),
        .SET_ADDR_LEN (SET_ADDR_LEN_DEF),
        .TAG_ADDR_LEN (TAG_ADDR_LEN_DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0][31:0] fill(input logic [31:0] base);
        logic [7:0][31:0] l;
        for (int i = 0; i < 8; i++)
            l[i] = base + 32'(i);
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.rd_req      = 1'b0;
        bus.wr_req      = 1'b0;
        bus.addr        = '0;
        bus.wr_data     = '0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rd_line = '0;
        #2;
        check("rst_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
        check("rst_mem_wr_req", 32'(bus.mem_wr_req), 32'd0);
        check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
        check("rst_rd_data",    bus.rd_data,         32'd0);
        check("rst_miss",       32'(bus.miss),       32'd0);
        check("rst_hit_cnt",    bus.hit_cnt,         32'd0);
        check("rst_miss_cnt",   bus.miss_cnt,        32'd0);
        @(negedge clk) rst = 1'b0;

        // Cold read miss on set 0 fills from memory without a write-back.
        @(negedge clk);
        bus.rd_req = 1'b1; bus.addr = 32'h0000_0000; #1;
        check("cold_miss",        32'(bus.miss),       32'd1);
        check("cold_idle_no_req", 32'(bus.mem_rd_req), 32'd0);
        @(negedge clk); #1;
        check("swapin_rd_req",    32'(bus.mem_rd_req), 32'd1);
        check("swapin_wr_req",    32'(bus.mem_wr_req), 32'd0);
        check("swapin_addr",      32'(bus.mem_addr),   32'd0);
        check("swapin_miss",      32'(bus.miss),       32'd1);
        @(negedge clk); #1;
        check("swapin_hold_req",  32'(bus.mem_rd_req), 32'd1);
        check("swapin_hold_addr", 32'(bus.mem_addr),   32'd0);
        bus.mem_rd_line = fill(32'h1000_0000); bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0; #1;
        check("inok_rd_req",      32'(bus.mem_rd_req), 32'd0);
        check("inok_miss",        32'(bus.miss),       32'd1);
        @(negedge clk); #1;
        check("fill_hit_miss",    32'(bus.miss),       32'd0);
        check("fill_hit_data",    bus.rd_data,         32'h1000_0000);

        // Write hit, then read back.
        @(negedge clk);
        bus.rd_req = 1'b0; bus.wr_req = 1'b1; bus.addr = 32'h0000_0004; bus.wr_data = 32'hDEAD_BEEF; #1;
        check("wr_hit_miss",      32'(bus.miss),       32'd0);
        @(negedge clk);
        bus.wr_req = 1'b0; bus.rd_req = 1'b1; #1;
        check("rd_back_data",     bus.rd_data,         32'hDEAD_BEEF);
        check("rd_back_miss",     32'(bus.miss),       32'd0);

        // Read and write together: read wins, word 2 keeps its fill value.
        @(negedge clk);
        bus.wr_req = 1'b1; bus.addr = 32'h0000_0008; bus.wr_data = 32'h5555_5555; #1;
        check("both_rd_data",     bus.rd_data,         32'h1000_0002);
        check("both_miss",        32'(bus.miss),       32'd0);
        @(negedge clk);
        bus.wr_req = 1'b0; #1;
        check("both_unchanged",   bus.rd_data,         32'h1000_0002);

        // Tag 1 in dirty set 0: write-back of line 0, then fetch of line 8.
        @(negedge clk);
        bus.addr = 32'h0000_0100; #1;
        check("evict_miss",       32'(bus.miss),       32'd1);
        check("evict_idle_wr",    32'(bus.mem_wr_req), 32'd0);
        @(negedge clk);
        bus.rd_req = 1'b0; bus.addr = 32'h0000_001C; #1;
        check("swapout_wr_req",   32'(bus.mem_wr_req), 32'd1);
        check("swapout_rd_req",   32'(bus.mem_rd_req), 32'd0);
        check("swapout_addr",     32'(bus.mem_addr),   32'd0);
        check("swapout_word1",    bus.mem_wr_line[1],  32'hDEAD_BEEF);
        check("swapout_word0",    bus.mem_wr_line[0],  32'h1000_0000);
        check("swapout_no_req",   32'(bus.miss),       32'd0);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0; #1;
        check("evict_in_rd_req",  32'(bus.mem_rd_req), 32'd1);
        check("evict_in_wr_req",  32'(bus.mem_wr_req), 32'd0);
        check("evict_in_addr",    32'(bus.mem_addr),   32'd8);
        @(negedge clk); #1;
        check("evict_in_hold",    32'(bus.mem_addr),   32'd8);
        bus.mem_rd_line = fill(32'h2000_0000); bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0; #1;
        check("evict_ok_rd_req",  32'(bus.mem_rd_req), 32'd0);
        @(negedge clk);
        bus.rd_req = 1'b1; bus.addr = 32'h0000_0104; #1;
        check("evict_hit_miss",   32'(bus.miss),       32'd0);
        check("evict_hit_data",   bus.rd_data,         32'h2000_0001);
        @(negedge clk);
        bus.rd_req = 1'b0; #1;
`ifdef DM_CACHE_STATS_EN
        // Six IDLE hit cycles and two miss starts issued so far.
        check("stats_hit_cnt",    bus.hit_cnt,         32'd6);
        check("stats_miss_cnt",   bus.miss_cnt,        32'd2);
`else
        check("stats_hit_cnt",    bus.hit_cnt,         32'd0);
        check("stats_miss_cnt",   bus.miss_cnt,        32'd0);
`endif

        // Reset during SWAP_IN drops the request and invalidates everything.
        @(negedge clk);
        bus.rd_req = 1'b1; bus.addr = 32'h0000_0000; #1;
        check("rstin_miss",       32'(bus.miss),       32'd1);
        @(negedge clk); #1;
        check("rstin_rd_req",     32'(bus.mem_rd_req), 32'd1);
        check("rstin_wr_req",     32'(bus.mem_wr_req), 32'd0);
        rst = 1'b1; #1;
        check("rst_abort_rd_req", 32'(bus.mem_rd_req), 32'd0);
        check("rst_abort_addr",   32'(bus.mem_addr),   32'd0);
        @(negedge clk);
        rst = 1'b0; bus.addr = 32'h0000_0100; #1;
        check("post_rst_miss",    32'(bus.miss),       32'd1);
        @(negedge clk); #1;
        check("post_rst_wr_req",  32'(bus.mem_wr_req), 32'd0);
        check("post_rst_rd_req",  32'(bus.mem_rd_req), 32'd1);
        check("post_rst_addr",    32'(bus.mem_addr),   32'd8);
        bus.mem_rd_line = fill(32'h3000_0000); bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        @(negedge clk); #1;
        check("post_rst_hit",     32'(bus.miss),       32'd0);
        check("post_rst_data",    bus.rd_data,         32'h3000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
